// File: rtl/cic_pkg.sv
// cic_pkg: helpers shared by the two-lane CIC interpolator and decimator.
package cic_pkg;
    localparam int RATE_W = 8;
    typedef logic [RATE_W-1:0] rate_t;
    function automatic int cic_width(input int win, input int n, input int rmax);
        return win + n * $clog2(rmax);
    endfunction
    function automatic rate_t clamp_rate(input rate_t r, input int rmax);
        return (r < rate_t'(2)) ? rate_t'(2) : (int'(r) > rmax) ? rate_t'(rmax) : r;
    endfunction
endpackage

// File: rtl/cic_int_stage.sv
// cic_int_stage: one two-lane integrator; the odd lane builds on the even-lane sum.
module cic_int_stage #(
    parameter int WIDTH = 36
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    adv,
    input  logic signed [WIDTH-1:0] e_in,
    input  logic signed [WIDTH-1:0] o_in,
    output logic signed [WIDTH-1:0] e_out,
    output logic signed [WIDTH-1:0] o_out
);
    logic signed [WIDTH-1:0] acc;
    assign e_out = acc + e_in;
    assign o_out = e_out + o_in;
    always_ff @(posedge clk) begin
        if (rst) acc <= '0;
        else if (adv) acc <= o_out;
    end
endmodule

// File: rtl/cic_interpolation.sv
// cic_interpolation: two-lane CIC interpolator; comb at input rate, zero-stuff by rate,
// integrators produce an even/odd output pair per clock.
module cic_interpolation
    import cic_pkg::*;
#(
    parameter int WIDTH_IN  = 16,
    parameter int NUM_STAGE = 5,
    parameter int MAX_RATE  = 16,
    parameter int WIDTH_OUT = cic_width(WIDTH_IN, NUM_STAGE, MAX_RATE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    input  logic [7:0]                  rate,
    input  logic signed [WIDTH_IN-1:0]  din,
    input  logic                        din_vld,
    output logic                        din_rdy,
    output logic signed [WIDTH_OUT-1:0] dout_even,
    output logic signed [WIDTH_OUT-1:0] dout_odd,
    output logic                        dout_vld,
    output logic                        underflow
);
    if (NUM_STAGE < 1) begin : g_chk_n
        $error("NUM_STAGE must be >= 1");
    end
    if (MAX_RATE < 2) begin : g_chk_r
        $error("MAX_RATE must be >= 2");
    end

    rate_t rate_q, ph, ph_next;
    logic [RATE_W:0] ph_sum;
    logic signed [WIDTH_OUT-1:0] comb_q;
    logic comb_q_full, running;
    logic imp_e, imp_o, imp, advance, consume, accept;

    assign imp_e   = ph == '0;
    assign imp_o   = ph + rate_t'(1) == rate_q;
    assign imp     = imp_e | imp_o;
    assign advance = ena & (!imp | comb_q_full);
    assign consume = advance & imp;
    assign din_rdy = ena & (!comb_q_full | consume);
    assign accept  = din_vld & din_rdy;
    // rate_q >= 2 keeps ph+2 below 2*rate_q, so one subtract wraps it
    assign ph_sum  = {1'b0, ph} + (RATE_W+1)'(2);
    assign ph_next = (ph_sum >= {1'b0, rate_q}) ? RATE_W'(ph_sum - {1'b0, rate_q}) : RATE_W'(ph_sum);

    for (genvar g = 0; g < NUM_STAGE; g++) begin : g_comb
        logic signed [WIDTH_OUT-1:0] x, y, d;
        if (g == 0) begin : g_src
            assign x = WIDTH_OUT'(din);
        end else begin : g_src
            assign x = g_comb[g-1].y;
        end
        assign y = x - d;
        always_ff @(posedge clk) begin
            if (rst) d <= '0;
            else if (accept) d <= x;
        end
    end

    for (genvar g = 0; g < NUM_STAGE; g++) begin : g_int
        logic signed [WIDTH_OUT-1:0] e_in, o_in, e_out, o_out;
        if (g == 0) begin : g_src
            assign e_in = imp_e ? comb_q : '0;
            assign o_in = imp_o ? comb_q : '0;
        end else begin : g_src
            assign e_in = g_int[g-1].e_out;
            assign o_in = g_int[g-1].o_out;
        end
        cic_int_stage #(.WIDTH(WIDTH_OUT)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .adv   (advance),
            .e_in  (e_in),
            .o_in  (o_in),
            .e_out (e_out),
            .o_out (o_out)
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rate_q      <= clamp_rate(rate, MAX_RATE);
            ph          <= '0;
            comb_q      <= '0;
            comb_q_full <= 1'b0;
            running     <= 1'b0;
            dout_even   <= '0;
            dout_odd    <= '0;
            dout_vld    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (accept) comb_q <= g_comb[NUM_STAGE-1].y;
            comb_q_full <= accept | (comb_q_full & !consume);
            running     <= running | accept;
            if (advance) begin
                ph        <= ph_next;
                dout_even <= g_int[NUM_STAGE-1].e_out;
                dout_odd  <= g_int[NUM_STAGE-1].o_out;
            end
            dout_vld  <= advance;
            underflow <= ena & imp & !comb_q_full & running;
        end
    end
endmodule

// File: tb/tb_cic_interpolation.sv
// tb_cic_interpolation: directed tests on a 1-stage and a 5-stage instance sharing stimulus.
module tb_cic_interpolation;
    localparam int W1 = 20;
    localparam int W5 = 36;

    logic clk = 1'b0, rst = 1'b1, ena = 1'b1, din_vld = 1'b0;
    logic [7:0] rate = 8'd4;
    logic signed [15:0] din = '0;
    logic rdy1, v1, u1, rdy5, v5, u5;
    logic signed [W1-1:0] e1, o1;
    logic signed [W5-1:0] e5, o5;
    int total = 0, bad = 0;

    // rate=3 reference run: din_rdy before each edge, and the pair registered at that edge
    int xr3[8] = '{1, 1, 1, 0, 1, 1, 0, 1};
    int xv3[8] = '{0, 1, 1, 1, 1, 1, 1, 1};
    int xe3[8] = '{0, 5, 5, 7, 9, 9, 11, 13};
    int xo3[8] = '{0, 5, 7, 7, 9, 11, 11, 13};

    always #5 clk = ~clk;

    cic_interpolation #(.WIDTH_IN(16), .NUM_STAGE(1), .MAX_RATE(16)) dut1 (
        .clk(clk), .rst(rst), .ena(ena), .rate(rate), .din(din), .din_vld(din_vld),
        .din_rdy(rdy1), .dout_even(e1), .dout_odd(o1), .dout_vld(v1), .underflow(u1)
    );
    cic_interpolation #(.WIDTH_IN(16), .NUM_STAGE(5), .MAX_RATE(16)) dut5 (
        .clk(clk), .rst(rst), .ena(ena), .rate(rate), .din(din), .din_vld(din_vld),
        .din_rdy(rdy5), .dout_even(e5), .dout_odd(o5), .dout_vld(v5), .underflow(u5)
    );

    task automatic cyc(input logic en, input logic vld, input int d, output logic r);
        ena = en;
        din_vld = vld;
        din = 16'(d);
        #1 r = rdy1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] r);
        rst = 1'b1;
        rate = r;
        ena = 1'b1;
        din_vld = 1'b0;
        din = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic r;
        do_reset(8'd4);
        total++;
        if (v1 !== 1'b0 || u1 !== 1'b0 || e1 !== '0 || o1 !== '0) begin
            bad++;
            $display("FAIL reset1: vld=%b uf=%b e=%0d o=%0d want 0 0 0 0", v1, u1, e1, o1);
        end
        total++;
        if (v5 !== 1'b0 || e5 !== '0 || o5 !== '0) begin
            bad++;
            $display("FAIL reset5: vld=%b e=%0d o=%0d want 0 0 0", v5, e5, o5);
        end
        total++;
        if (rdy1 !== 1'b1) begin
            bad++;
            $display("FAIL reset_rdy: got %b want 1", rdy1);
        end
        for (int c = 0; c < 3; c++) begin
            cyc(1'b1, 1'b0, 0, r);
            total++;
            if (v1 !== 1'b0 || u1 !== 1'b0) begin
                bad++;
                $display("FAIL idle_silent c%0d: vld=%b uf=%b want 0 0", c, v1, u1);
            end
        end
    endtask

    // din 1000 then zeros on the 1-stage instance: n pairs of 1000 then a (0,0) pair
    task automatic test_impulse(input logic [7:0] rr, input int n);
        logic r;
        int want;
        do_reset(rr);
        for (int c = 0; c <= n + 1; c++) begin
            cyc(1'b1, 1'b1, (c == 0) ? 1000 : 0, r);
            want = (c == 0) ? 0 : (c <= n) ? 1000 : 0;
            total++;
            if (v1 !== (c != 0) || e1 !== W1'(want) || o1 !== W1'(want)) begin
                bad++;
                $display("FAIL impulse rate=%0d c%0d: vld=%b e=%0d o=%0d want %b %0d %0d",
                         rr, c, v1, e1, o1, c != 0, want, want);
            end
        end
    endtask

    task automatic test_dc_gain();
        logic r;
        do_reset(8'd4);
        for (int c = 0; c < 40; c++) cyc(1'b1, 1'b1, 1, r);
        for (int c = 0; c < 4; c++) begin
            cyc(1'b1, 1'b1, 1, r);
            total++;
            if (v5 !== 1'b1 || e5 !== W5'(256) || o5 !== W5'(256)) begin
                bad++;
                $display("FAIL dc5 c%0d: vld=%b e=%0d o=%0d want 1 256 256", c, v5, e5, o5);
            end
            total++;
            if (v1 !== 1'b1 || e1 !== W1'(1) || o1 !== W1'(1)) begin
                bad++;
                $display("FAIL dc1 c%0d: vld=%b e=%0d o=%0d want 1 1 1", c, v1, e1, o1);
            end
        end
    endtask

    task automatic test_rate3();
        logic r;
        int idx = 0;
        do_reset(8'd3);
        for (int c = 0; c < 8; c++) begin
            cyc(1'b1, 1'b1, 5 + 2 * idx, r);
            if (r) idx++;
            total++;
            if (int'(r) !== xr3[c]) begin
                bad++;
                $display("FAIL rate3_rdy c%0d: got %b want %0d", c, r, xr3[c]);
            end
            total++;
            if (int'(v1) !== xv3[c] || e1 !== W1'(xe3[c]) || o1 !== W1'(xo3[c])) begin
                bad++;
                $display("FAIL rate3_pair c%0d: vld=%b e=%0d o=%0d want %0d %0d %0d",
                         c, v1, e1, o1, xv3[c], xe3[c], xo3[c]);
            end
        end
    endtask

    task automatic test_underflow();
        logic r;
        int sv[9] = '{1, 1, 1, 0, 0, 0, 1, 1, 0};
        int sd[9] = '{10, 20, 30, 0, 0, 0, 40, 50, 0};
        int xv[9] = '{0, 1, 1, 1, 0, 0, 0, 1, 1};
        int xu[9] = '{0, 0, 0, 0, 1, 1, 1, 0, 0};
        int xd[9] = '{0, 10, 20, 30, 30, 30, 30, 40, 50};
        do_reset(8'd2);
        for (int c = 0; c < 9; c++) begin
            cyc(1'b1, sv[c] != 0, sd[c], r);
            total++;
            if (int'(v1) !== xv[c] || int'(u1) !== xu[c] || e1 !== W1'(xd[c]) || o1 !== W1'(xd[c])) begin
                bad++;
                $display("FAIL underflow c%0d: vld=%b uf=%b e=%0d o=%0d want %0d %0d %0d %0d",
                         c, v1, u1, e1, o1, xv[c], xu[c], xd[c], xd[c]);
            end
        end
    endtask

    task automatic test_ena_toggle();
        logic r;
        int idx = 0;
        int j = 0;
        do_reset(8'd3);
        for (int i = 0; i < 16; i++) begin
            cyc(i % 2 == 0, 1'b1, 5 + 2 * idx, r);
            if (r) idx++;
            total++;
            if (i % 2 == 0) begin
                if (int'(r) !== xr3[j] || int'(v1) !== xv3[j] || e1 !== W1'(xe3[j]) || o1 !== W1'(xo3[j])) begin
                    bad++;
                    $display("FAIL ena_on i%0d: rdy=%b vld=%b e=%0d o=%0d want %0d %0d %0d %0d",
                             i, r, v1, e1, o1, xr3[j], xv3[j], xe3[j], xo3[j]);
                end
                j++;
            end else if (r !== 1'b0 || v1 !== 1'b0 || u1 !== 1'b0) begin
                bad++;
                $display("FAIL ena_off i%0d: rdy=%b vld=%b uf=%b want 0 0 0", i, r, v1, u1);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic r;
        int want;
        do_reset(8'd4);
        for (int c = 0; c < 10; c++) cyc(1'b1, 1'b1, 1000, r);
        rst = 1'b1;
        rate = 8'd6;
        din_vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (v1 !== 1'b0 || e1 !== '0 || o1 !== '0 || v5 !== 1'b0 || e5 !== '0 || o5 !== '0) begin
            bad++;
            $display("FAIL mid_reset: v1=%b e1=%0d o1=%0d v5=%b e5=%0d o5=%0d want all 0",
                     v1, e1, o1, v5, e5, o5);
        end
        for (int c = 0; c < 5; c++) begin
            cyc(1'b1, 1'b1, (c == 0) ? 1000 : 0, r);
            want = (c >= 1 && c <= 3) ? 1000 : 0;
            total++;
            if (v1 !== (c != 0) || e1 !== W1'(want) || o1 !== W1'(want)) begin
                bad++;
                $display("FAIL rate6_impulse c%0d: vld=%b e=%0d o=%0d want %b %0d %0d",
                         c, v1, e1, o1, c != 0, want, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse(8'd4, 2);
        test_impulse(8'd0, 1);
        test_impulse(8'd200, 8);
        test_dc_gain();
        test_rate3();
        test_underflow();
        test_ena_toggle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
